// File: rtl/ctrl_pipe_decoder_pkg.sv
// ctrl_pipe_decoder_pkg: opcodes, ALUOp codes, control bundle and stage register types, plus the load-use match helper
package ctrl_pipe_decoder_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_IMM    = 3'b001;
  localparam logic [2:0] ALUOP_LUI    = 3'b010;
  localparam logic [2:0] ALUOP_STORE  = 3'b011;
  localparam logic [2:0] ALUOP_REG    = 3'b100;
  localparam logic [2:0] ALUOP_BRANCH = 3'b101;
  localparam logic [2:0] ALUOP_AUIPC  = 3'b110;
  localparam logic [2:0] ALUOP_ILL    = 3'b111;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic mem_to_reg;
    logic pc4;
  } ctrl_t;
  typedef struct packed {
    ctrl_t       c;
    logic [2:0]  alu_op;
    logic [4:0]  rd;
  } idex_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc4;
    logic [4:0] rd;
  } exmem_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc4;
    logic [4:0] rd;
  } memwb_t;
  function automatic logic rs_hit(logic ld, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                  logic u1, logic u2);
    return ld && rd != 5'd0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction
endpackage

// File: rtl/ctrl_pipe_decoder_table.sv
// ctrl_decode_table: combinational opcode -> control bundle, ALUOp, source-register usage and legality
module ctrl_decode_table
  import ctrl_pipe_decoder_pkg::*;
#(
  parameter bit EN_JUMP  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic [2:0] alu_op_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       legal_o
);
  always_comb begin
    ctrl_o    = '0;
    alu_op_o  = ALUOP_ILL;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    legal_o   = 1'b1;
    case (opcode_i)
      OP_LOAD:   begin ctrl_o = 8'b1100_0110; alu_op_o = ALUOP_ADD;    use_rs1_o = 1'b1; end
      OP_IMM:    begin ctrl_o = 8'b1000_0100; alu_op_o = ALUOP_IMM;    use_rs1_o = 1'b1; end
      OP_STORE:  begin ctrl_o = 8'b0010_0100; alu_op_o = ALUOP_STORE;  use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
      OP_REG:    begin ctrl_o = 8'b1000_0000; alu_op_o = ALUOP_REG;    use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
      OP_BRANCH: begin ctrl_o = 8'b0001_0000; alu_op_o = ALUOP_BRANCH; use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
      OP_LUI:    if (EN_UPPER) begin ctrl_o = 8'b1000_0100; alu_op_o = ALUOP_LUI;   end else legal_o = 1'b0;
      OP_AUIPC:  if (EN_UPPER) begin ctrl_o = 8'b1000_0100; alu_op_o = ALUOP_AUIPC; end else legal_o = 1'b0;
      OP_JAL:    if (EN_JUMP)  begin ctrl_o = 8'b1000_1101; alu_op_o = ALUOP_ADD;   end else legal_o = 1'b0;
      OP_JALR:   if (EN_JUMP)  begin ctrl_o = 8'b1000_1101; alu_op_o = ALUOP_ADD; use_rs1_o = 1'b1; end else legal_o = 1'b0;
      default:   legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: ID decode, ID/EX-EX/MEM-MEM/WB control pipeline with load-use stall, flush bubbles and external freeze
module ctrl_pipe_decoder
  import ctrl_pipe_decoder_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               hazard_stall,
  output logic               illegal_instr,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [4:0]         ex_rd,
  output logic               mem_read,
  output logic               mem_write,
  output logic [4:0]         mem_rd,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_pc4,
  output logic [4:0]         wb_rd
);
  localparam int CW = $clog2(LOAD_LAT + 1);
  ctrl_t          tbl_ctrl, dec_ctrl;
  logic [2:0]     dec_alu_op;
  logic           use_rs1, use_rs2, legal, detect;
  idex_t          ex_q, ex_d;
  exmem_t         mem_q, mem_d;
  memwb_t         wb_q, wb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  ctrl_decode_table #(.EN_JUMP(EN_JUMP), .EN_UPPER(EN_UPPER)) u_table (
    .opcode_i (id_opcode),
    .ctrl_o   (tbl_ctrl),
    .alu_op_o (dec_alu_op),
    .use_rs1_o(use_rs1),
    .use_rs2_o(use_rs2),
    .legal_o  (legal)
  );
  always_comb begin
    dec_ctrl = tbl_ctrl;
    dec_ctrl.reg_write = tbl_ctrl.reg_write & id_valid & (id_rd != 5'd0);
  end
  assign detect = id_valid & (rs_hit(ex_q.c.mem_read, ex_q.rd, id_rs1, id_rs2, use_rs1, use_rs2) |
                  ((LOAD_LAT >= 2) & rs_hit(mem_q.mem_read, mem_q.rd, id_rs1, id_rs2, use_rs1, use_rs2)));
  assign hazard_stall  = !flush_in & (detect | (cnt_q != '0));
  assign illegal_instr = id_valid & !legal;
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!stall_in) begin
      mem_d = '{reg_write: ex_q.c.reg_write, mem_read: ex_q.c.mem_read, mem_write: ex_q.c.mem_write,
                mem_to_reg: ex_q.c.mem_to_reg, pc4: ex_q.c.pc4, rd: ex_q.rd};
      wb_d  = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, pc4: mem_q.pc4, rd: mem_q.rd};
      ex_d  = (flush_in | hazard_stall) ? '0 : idex_t'{c: dec_ctrl, alu_op: dec_alu_op, rd: id_rd};
      cnt_d = flush_in ? '0 :
              (detect && cnt_q == '0) ? CW'(LOAD_LAT - 1) :
              (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end
  assign ex_alu_src    = ex_q.c.alu_src;
  assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
  assign ex_branch     = ex_q.c.branch;
  assign ex_jump       = ex_q.c.jump;
  assign ex_rd         = ex_q.rd;
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign mem_rd        = mem_q.rd;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_pc4        = wb_q.pc4;
  assign wb_rd         = wb_q.rd;
endmodule
